// File: rtl/usb_crc_pkg.sv
// Shared constants and types for the USB CRC5 generator and checker.
// CRC values are held in reflected form: bit 0 is the next bit to leave the register.
package usb_crc_pkg;

  localparam int unsigned CRC5_DATA_W = 11;
  localparam int unsigned CRC5_W      = 5;

  localparam logic [4:0] CRC5_INIT          = 5'b11111;
  localparam logic [4:0] CRC5_POLY_REFL     = 5'b10100;
  localparam logic [4:0] CRC5_RESIDUAL_REFL = 5'b00110;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StCrc,
    StDone
  } crc5_state_e;

endpackage

// File: rtl/usb_crc5_step.sv
// Combinational single-bit update of a reflected CRC5 register.
// Shared by the transmit generator and the receive checker.
module usb_crc5_step
  import usb_crc_pkg::*;
#(
  parameter logic [4:0] POLY = CRC5_POLY_REFL
) (
  input  logic [4:0] crc,
  input  logic       din,
  output logic [4:0] crc_next
);

  logic fb;

  assign fb       = crc[0] ^ din;
  assign crc_next = fb ? ((crc >> 1) ^ POLY) : (crc >> 1);

endmodule

// File: rtl/usb_crc5_gen.sv
// Serializes an 11-bit token/SOF field LSB first and appends its complemented CRC5.
// All serial advancement happens on the shift_en bit-time strobe.
module usb_crc5_gen
  import usb_crc_pkg::*;
#(
  // Only the USB width of 11 is supported.
  parameter int unsigned DATA_W   = CRC5_DATA_W,
  parameter logic [4:0]  CRC_INIT = CRC5_INIT,
  parameter logic [4:0]  CRC_POLY = CRC5_POLY_REFL
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              shift_en,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] d,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic [4:0]        crc_out
);

  localparam int unsigned     CntW     = $clog2(DATA_W);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CrcLast  = CntW'(CRC5_W - 1);

  crc5_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [4:0]        crc_q, crc_d;
  logic [4:0]        crcsh_q, crcsh_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [4:0]        crc_out_q, crc_out_d;
  logic [4:0]        crc_step;

  usb_crc5_step #(
    .POLY (CRC_POLY)
  ) u_step (
    .crc      (crc_q),
    .din      (shreg_q[0]),
    .crc_next (crc_step)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    crc_d     = crc_q;
    crcsh_d   = crcsh_q;
    count_d   = count_q;
    crc_out_d = crc_out_q;
    unique case (state_q)
      StIdle: begin
        // A coincident shift_en is ignored here: the first bit needs a full bit time.
        if (start) begin
          shreg_d = d;
          crc_d   = CRC_INIT;
          count_d = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (abort) begin
          state_d = StIdle;
        end else if (shift_en) begin
          crc_d   = crc_step;
          shreg_d = shreg_q >> 1;
          count_d = count_q + CntW'(1);
          if (count_q == DataLast) begin
            // Use the post-update CRC so the last data bit is included.
            crcsh_d   = ~crc_step;
            crc_out_d = ~crc_step;
            count_d   = '0;
            state_d   = StCrc;
          end
        end
      end
      StCrc: begin
        if (abort) begin
          state_d = StIdle;
        end else if (shift_en) begin
          crcsh_d = crcsh_q >> 1;
          count_d = count_q + CntW'(1);
          if (count_q == CrcLast) begin
            count_d = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StData: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = shreg_q[0];
      end
      StCrc: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_bit   = crcsh_q[0];
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign crc_out = crc_out_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      crc_q     <= CRC_INIT;
      crcsh_q   <= '0;
      count_q   <= '0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      crc_q     <= crc_d;
      crcsh_q   <= crcsh_d;
      count_q   <= count_d;
      crc_out_q <= crc_out_d;
    end
  end

endmodule

// File: tb/tb_usb_crc5_gen.sv
// Self-checking bench for usb_crc5_gen: a transaction-level model plus directed vectors.
// Inputs change 1 time unit after posedge; the model compare runs on negedge.
module tb_usb_crc5_gen;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        shift_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] d = '0;
  logic        tx_bit, tx_valid, busy, done;
  logic [4:0]  crc_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  usb_crc5_gen dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (shift_en),
    .start    (start),
    .abort    (abort),
    .d        (d),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done),
    .crc_out  (crc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC in non-reflected (MSB-first register) form, x^5+x^2+1, seed all ones.
  // Returns the remainder bit-reversed so it reads like the reflected register.
  function automatic logic [4:0] crc5_ref(input logic [15:0] bits, input int n);
    logic [4:0] c;
    logic       fb;
    c = 5'b11111;
    for (int i = 0; i < n; i++) begin
      fb = c[4] ^ bits[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  // Wire order: bit i is the i-th bit transmitted.
  function automatic logic [15:0] wire_bits(input logic [10:0] dv);
    logic [15:0] w;
    w        = '0;
    w[10:0]  = dv;
    w[15:11] = ~crc5_ref(w, 11);
    return w;
  endfunction

  // Transaction-level model.
  bit          mdl_en = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_after_rst = 1'b0;
  int          m_idx = 0;
  logic [15:0] m_bits = '0;
  logic [4:0]  m_crc_out = '0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_active    = 1'b0;
      m_done      = 1'b0;
      m_crc_out   = '0;
      m_after_rst = 1'b1;
      m_idx       = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_bits      = wire_bits(d);
        m_active    = 1'b1;
        m_idx       = 0;
        m_after_rst = 1'b0;
      end
    end else if (abort) begin
      m_active = 1'b0;
    end else if (shift_en) begin
      if (m_idx == 10) m_crc_out = m_bits[15:11];
      m_idx++;
      if (m_idx == 16) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
    if (mdl_en) begin
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, m_active});
      chk("busy", {15'b0, busy}, {15'b0, m_active});
      chk("done", {15'b0, done}, {15'b0, m_done});
      if (m_active) chk("tx_bit", {15'b0, tx_bit}, {15'b0, m_bits[m_idx]});
      if (m_after_rst) chk("tx_bit_idle", {15'b0, tx_bit}, 16'h0);
      if (m_done || m_after_rst) chk("crc_out", {11'b0, crc_out}, {11'b0, m_crc_out});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_field(input logic [10:0] dv, input int gap, output logic [15:0] cap,
                           output logic [4:0] co, output bit saw_done);
    start = 1'b1;
    d     = dv;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap[i]   = tx_bit;
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      if (i < 15) repeat (gap - 1) tick();
    end
    saw_done = done;
    co       = crc_out;
    tick();
  endtask

  logic [15:0] cap;
  logic [4:0]  co;
  bit          sd;
  int          nd0;
  int          stall_bad;
  logic        hold;
  logic [10:0] rd;

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst_tx_bit", {15'b0, tx_bit}, 16'h0);
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_done", {15'b0, done}, 16'h0);
    chk("rst_crc_out", {11'b0, crc_out}, 16'h0);
    mdl_en = 1'b1;
    n_rst  = 1'b1;
    tick();

    // Pin the model against hand-computed values.
    chk("model_d000", wire_bits(11'h000), 16'h1000);
    chk("model_d001", wire_bits(11'h001), 16'hE801);

    // d = 0, strobe every 4 clks
    nd0 = n_done;
    run_field(11'h000, 4, cap, co, sd);
    chk("d000_wire", cap, 16'h1000);
    chk("d000_crc_out", {11'b0, co}, 16'h0002);
    chk("d000_done_seen", {15'b0, sd}, 16'h1);
    chk("d000_done_once", 16'(n_done - nd0), 16'h1);

    // d = 1
    run_field(11'h001, 2, cap, co, sd);
    chk("d001_wire_crc", {11'b0, cap[15:11]}, 16'h001D);
    chk("d001_crc_out", {11'b0, co}, 16'h001D);

    // Random fields: the 16 emitted bits must leave the fixed residual.
    for (int k = 0; k < 200; k++) begin
      rd = 11'($urandom_range(0, 2047));
      run_field(rd, 1, cap, co, sd);
      chk("residual", {11'b0, crc5_ref(cap, 16)}, 16'h0006);
    end

    // Abort after the 6th data bit
    nd0   = n_done;
    start = 1'b1;
    d     = 11'h5A5;
    tick();
    start = 1'b0;
    repeat (6) begin
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("abort_busy", {15'b0, busy}, 16'h0);
    repeat (5) tick();
    chk("abort_no_done", 16'(n_done - nd0), 16'h0);
    run_field(11'h000, 2, cap, co, sd);
    chk("after_abort_crc_out", {11'b0, co}, 16'h0002);

    // Reset during the CRC phase
    nd0   = n_done;
    start = 1'b1;
    d     = 11'h2B3;
    tick();
    start = 1'b0;
    repeat (13) begin
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      tick();
    end
    chk("pre_rst_busy", {15'b0, busy}, 16'h1);
    n_rst = 1'b0;
    tick();
    chk("mid_rst_outputs", {10'b0, tx_bit, tx_valid, busy, done, 2'b0},
        16'h0);
    chk("mid_rst_crc_out", {11'b0, crc_out}, 16'h0);
    n_rst = 1'b1;
    tick();
    chk("mid_rst_no_done", 16'(n_done - nd0), 16'h0);

    // start held through the field and through DONE
    start = 1'b1;
    d     = 11'h1F0;
    tick();
    for (int i = 0; i < 16; i++) begin
      cap[i]   = tx_bit;
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      if (i < 15) tick();
    end
    chk("held_wire", cap, wire_bits(11'h1F0));
    chk("held_done", {15'b0, done}, 16'h1);
    tick();
    chk("held_idle_busy", {15'b0, busy}, 16'h0);
    tick();
    chk("held_restart_busy", {15'b0, busy}, 16'h1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Stall: shift_en low for 50 clks mid-field
    nd0   = n_done;
    start = 1'b1;
    d     = 11'h3C5;
    tick();
    start = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 16; i++) begin
      cap[i] = tx_bit;
      if (i == 5) begin
        hold = tx_bit;
        repeat (50) begin
          tick();
          if (tx_bit !== hold || tx_valid !== 1'b1) stall_bad++;
        end
      end
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      if (i < 15) tick();
    end
    tick();
    chk("stall_hold", 16'(stall_bad), 16'h0);
    chk("stall_wire", cap, wire_bits(11'h3C5));
    chk("stall_done_once", 16'(n_done - nd0), 16'h1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
